// File: rtl/charlieplex_pwm_display.sv
// charlieplex_pwm_display
// Grayscale charlieplexed LED driver. Each pixel owns a slot of 2^DEPTH
// cycles: one blank cycle followed by PWM phases where the pixel is lit
// while its level is at least the phase. A double buffer (back/front)
// keeps frames tear-free: the front buffer only changes on the edge that
// presents frame cycle 0 while a swap request is pending.

// Smallest pin count N with N*(N-1) >= leds; evaluated at elaboration only.
function automatic int charlieplex_pin_count(input int leds);
  int n;
  n = 2;
  while (n * (n - 1) < leds) begin
    n = n + 1;
  end
  return n;
endfunction

module charlieplex_pwm_display #(
  parameter int PIXELCOUNT = 12,
  parameter int DEPTH      = 4,
  localparam int PINCOUNT  = charlieplex_pin_count(PIXELCOUNT),
  localparam int ADDRBITS  = (PIXELCOUNT > 2) ? $clog2(PIXELCOUNT) : 1
) (
  input  logic                pixelclock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                wr_en,
  input  logic [ADDRBITS-1:0] wr_addr,
  input  logic [DEPTH-1:0]    wr_data,
  input  logic                swap,
  output logic                swap_done,
  output logic                frame_start,
  output logic [PINCOUNT-1:0] out_en,
  output logic [PINCOUNT-1:0] out_value
);

  localparam logic [DEPTH-1:0]    PHASE_MAX  = {DEPTH{1'b1}};
  localparam logic [DEPTH-1:0]    PHASE_ZERO = {DEPTH{1'b0}};
  localparam logic [ADDRBITS-1:0] PIXEL_ZERO = {ADDRBITS{1'b0}};
  localparam logic [ADDRBITS-1:0] LAST_PIXEL = ADDRBITS'(PIXELCOUNT - 1);
  localparam logic [ADDRBITS:0]   ADDR_LIMIT = (ADDRBITS + 1)'(PIXELCOUNT);
  localparam logic [PINCOUNT-1:0] ONE_HOT    = PINCOUNT'(1);
  localparam logic [PINCOUNT-1:0] PINS_OFF   = {PINCOUNT{1'b0}};

  // Scan position of the frame cycle presented on the next edge.
  logic [DEPTH-1:0]    phase_r;
  logic [ADDRBITS-1:0] pixel_r;

  logic [DEPTH-1:0] back_r  [PIXELCOUNT];
  logic [DEPTH-1:0] front_r [PIXELCOUNT];
  logic             swap_pending_r;

  logic [DEPTH-1:0]    cur_level_s;
  logic                frame_zero_s;
  logic                lit_s;
  logic                do_swap_s;
  logic                wr_hit_s;
  int                  led_col_s;
  int                  led_rem_s;
  int                  led_row_s;
  logic [PINCOUNT-1:0] led_en_s;
  logic [PINCOUNT-1:0] led_val_s;

  // Decode the current scan position into lit/pin patterns and swap intent.
  always_comb begin
    cur_level_s  = front_r[pixel_r];
    frame_zero_s = (pixel_r == PIXEL_ZERO) && (phase_r == PHASE_ZERO);
    lit_s        = enable && (phase_r != PHASE_ZERO) && (cur_level_s >= phase_r);
    do_swap_s    = frame_zero_s && (swap_pending_r || swap);
    wr_hit_s     = wr_en && ({1'b0, wr_addr} < ADDR_LIMIT);
    led_col_s    = int'(pixel_r) / (PINCOUNT - 1);
    led_rem_s    = int'(pixel_r) % (PINCOUNT - 1);
    // The row skips over the column pin, since an LED cannot share both ends.
    if (led_rem_s < led_col_s) begin
      led_row_s = led_rem_s;
    end else begin
      led_row_s = led_rem_s + 1;
    end
    led_en_s  = (ONE_HOT << led_col_s) | (ONE_HOT << led_row_s);
    led_val_s = ONE_HOT << led_col_s;
  end

  // Advance phase within the slot, then pixel within the frame, gap-free.
  always_ff @(posedge pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      phase_r <= PHASE_ZERO;
      pixel_r <= PIXEL_ZERO;
    end else if (phase_r == PHASE_MAX) begin
      phase_r <= PHASE_ZERO;
      if (pixel_r == LAST_PIXEL) begin
        pixel_r <= PIXEL_ZERO;
      end else begin
        pixel_r <= pixel_r + ADDRBITS'(1);
      end
    end else begin
      phase_r <= phase_r + DEPTH'(1);
    end
  end

  // Register pin drive and the frame/swap strobes for the presented cycle.
  always_ff @(posedge pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      out_en      <= PINS_OFF;
      out_value   <= PINS_OFF;
      frame_start <= 1'b0;
      swap_done   <= 1'b0;
    end else begin
      if (lit_s) begin
        out_en    <= led_en_s;
        out_value <= led_val_s;
      end else begin
        out_en    <= PINS_OFF;
        out_value <= PINS_OFF;
      end
      frame_start <= frame_zero_s;
      swap_done   <= do_swap_s;
    end
  end

  // Hold one merged swap request until the next frame boundary consumes it.
  always_ff @(posedge pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      swap_pending_r <= 1'b0;
    end else if (do_swap_s) begin
      swap_pending_r <= 1'b0;
    end else if (swap) begin
      swap_pending_r <= 1'b1;
    end else begin
      swap_pending_r <= swap_pending_r;
    end
  end

  // Back buffer write port; out-of-range addresses are dropped.
  always_ff @(posedge pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIXELCOUNT; i++) begin
        back_r[i] <= PHASE_ZERO;
      end
    end else if (wr_hit_s) begin
      back_r[wr_addr] <= wr_data;
    end else begin
      back_r <= back_r;
    end
  end

  // Front buffer takes the pre-edge back buffer only at a frame boundary.
  always_ff @(posedge pixelclock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PIXELCOUNT; i++) begin
        front_r[i] <= PHASE_ZERO;
      end
    end else if (do_swap_s) begin
      front_r <= back_r;
    end else begin
      front_r <= front_r;
    end
  end

endmodule
